ahb_bus_arbiter: RTL
====================

// Module: ahb_bus_arbiter
// PURPOSE
//  Multi-master AHB arbiter. Grants the shared address/control/write-data path to one of NUM_MASTERS requesters.
//  Drives HGRANT, HMASTER and HMASTLOCK seen by the bus monitor/top and the slave mux.
//  Round-robin fairness. Fixed-length bursts and locked sequences are never broken.
//  Falls back to a default master when nobody requests.
// PARAMETERS
//  NUM_MASTERS   4   requesters, 2..16 (HMASTER is 4 bits)
//  DEFAULT_MST   0   master granted when no HBUSREQ is asserted
// PORTS
//  HCLK        in   1            bus clock; all state updates on rising edge
//  HRESETn     in   1            asynchronous, active-low reset
//  HBUSREQ     in   NUM_MASTERS  per-master bus request
//  HLOCK       in   NUM_MASTERS  per-master lock request, qualified by HBUSREQ
//  HTRANS      in   2            transfer type from the currently owning master
//  HBURST      in   3            burst type from the currently owning master
//  HREADY      in   1            bus ready; transfer/phase advance qualifier
//  HRESP       in   1            1 = ERROR
//  HGRANT      out  NUM_MASTERS  one-hot grant, registered
//  HMASTER     out  4            address-phase owner index, registered
//  HMASTLOCK   out  1            current address phase is locked, registered
// BEHAVIOUR
//  Reset values: HGRANT = one-hot(DEFAULT_MST); HMASTER = DEFAULT_MST; HMASTLOCK = 0; RR pointer = DEFAULT_MST; beat counter = 0; state = ARB.
//  FSM states:
//  - ARB: re-arbitration allowed on any HREADY=1 cycle.
//  - BURST: fixed-length burst in progress; grant frozen.
//  - LOCKED: owner holds HLOCK; grant frozen.
//  Grant selection (ARB state, HREADY=1):
//  - Pick the first requester after the RR pointer (wrapping NUM_MASTERS-1 -> 0).
//  - No requester: select DEFAULT_MST.
//  - HGRANT updates on the next edge. The RR pointer moves to the winner.
//  Handover:
//  - HMASTER <= index(HGRANT) and HMASTLOCK <= HLOCK[index] on each edge where HREADY=1.
//  - HMASTER therefore lags HGRANT by exactly one HREADY-qualified cycle.
//  - HREADY=0: HGRANT, HMASTER and HMASTLOCK all hold.
//  Bursts (counted on HTRANS=NONSEQ with HREADY=1, owner's HBURST sampled):
//  - WRAP4/INCR4 -> 4 beats; WRAP8/INCR8 -> 8 beats; WRAP16/INCR16 -> 16 beats.
//  - Enter BURST with counter = len-1. Decrement on each SEQ accepted with HREADY=1.
//  - BUSY and IDLE do not decrement.
//  - When counter reaches 1, re-arbitration is enabled, so the new grant appears while the last beat's address phase is accepted.
//  - Counter 0 -> ARB.
//  - SINGLE/INCR: stay in ARB; re-arbitrate every HREADY beat.
//  Lock:
//  - If the granted master has HLOCK=1 and HBUSREQ=1 -> LOCKED.
//  - Other requests are ignored until that HLOCK drops.
//  - Then one more HREADY cycle is held (the last locked address phase completes), then ARB.
//  - Lock takes priority over burst termination.
//  ERROR: HRESP=1 with HREADY=1 in BURST clears the counter and returns to ARB (not LOCKED, unless HLOCK is still high).
//  Simultaneous events: a request arriving in the same cycle as burst end competes normally. Owner dropping HBUSREQ mid-burst does not end the burst.
//  HRESETn low mid-burst or mid-lock: immediate return to reset values; no completion.
// STRUCTURE
//  ahb_pkg: htrans_t {IDLE,BUSY,NONSEQ,SEQ}; hburst_t (8 codes); arb_state_t {ARB,BURST,LOCKED}; function burst_beats(hburst_t) -> int.
//  Sub-module ahb_rr_arbiter: combinational round-robin pick from (req vector, pointer) -> one-hot + index + valid.
//  Top holds the FSM, beat counter, pointer and output registers.
// TESTING
//  1. Reset, no requests -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0; stays so for 20 cycles.
//  2. HBUSREQ=4'b1110 held, SINGLE transfers -> grant rotates 1,2,3,1...; HMASTER follows one cycle later.
//  3. M2 INCR8 (NONSEQ + 7 SEQ, 2 BUSY inserted), M1 requesting -> M2 keeps grant for all 8 beats; M1 granted in the cycle the 8th address is accepted.
//  4. M3 HLOCK=1 for 5 transfers while M0 and M1 request -> HMASTLOCK=1 on those 5 address phases; grant returns only after HLOCK drops plus one HREADY cycle.
//  5. HREADY=0 for 3 cycles during handover -> HGRANT, HMASTER and HMASTLOCK frozen; counter unchanged.
//  6. ERROR on beat 3 of INCR16 -> ARB next cycle and a waiting master is granted. HRESETn pulsed mid-burst -> reset values asynchronously.

Source files
------------

// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_pkg
//  Purpose  : Shared AHB types for the bus arbiter: transfer type, burst type,
//             arbiter FSM state, and the burst-length lookup.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    BURST  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  localparam int CNT_W = 5;

  // Beats in a fixed-length burst; SINGLE and undefined-length INCR report 1
  // so they never freeze the grant.
  function automatic int burst_beats(input hburst_t b);
    case (b)
      WRAP4,  INCR4  : return 4;
      WRAP8,  INCR8  : return 8;
      WRAP16, INCR16 : return 16;
      default        : return 1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_rr_arbiter
//  Purpose  : Combinational round-robin pick. The first requester strictly
//             after ptr (wrapping) wins; the master at ptr itself has the
//             lowest priority. With no requester, DEFAULT_MST is returned.
//  Ports    : req          in  NUM_MASTERS  request vector
//             ptr          in  4            last winner
//             grant_onehot out NUM_MASTERS  one-hot winner
//             grant_idx    out 4            winner index
//             valid        out 1            at least one requester present
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int DEFAULT_MST = 0
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [3:0]             ptr,
  output logic [NUM_MASTERS-1:0] grant_onehot,
  output logic [3:0]             grant_idx,
  output logic                   valid
);

  // Distance from ptr to each master, 1..NUM_MASTERS; the smallest distance
  // among requesters wins. ptr itself sits at distance NUM_MASTERS.
  logic [4:0] w_dist;
  logic [4:0] w_best;

  always_comb begin
    grant_idx = 4'(DEFAULT_MST);
    valid     = 1'b0;
    w_best    = 5'h1F;
    w_dist    = 5'd0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_dist = (4'(i) > ptr) ? (5'(i) - {1'b0, ptr})
                             : (5'(i) + 5'(NUM_MASTERS) - {1'b0, ptr});
      if (req[i] && (w_dist < w_best)) begin
        w_best    = w_dist;
        grant_idx = 4'(i);
        valid     = 1'b1;
      end
    end
    grant_onehot = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      grant_onehot[i] = (grant_idx == 4'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_bus_arbiter
//  Purpose  : Multi-master AHB arbiter with round-robin fairness, unbroken
//             fixed-length bursts, locked sequences and a default master.
//  Ports    : HCLK       in  1            bus clock
//             HRESETn    in  1            asynchronous active-low reset
//             HBUSREQ    in  NUM_MASTERS  per-master bus request
//             HLOCK      in  NUM_MASTERS  per-master lock request
//             HTRANS     in  2            owner transfer type
//             HBURST     in  3            owner burst type
//             HREADY     in  1            transfer advance qualifier
//             HRESP      in  1            1 = ERROR
//             HGRANT     out NUM_MASTERS  registered one-hot grant
//             HMASTER    out 4            registered address-phase owner
//             HMASTLOCK  out 1            registered lock of address phase
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int DEFAULT_MST = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic                   HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [3:0]             HMASTER,
  output logic                   HMASTLOCK
);

  import ahb_pkg::*;

  localparam logic [3:0]             C_DEFAULT_IDX   = 4'(DEFAULT_MST);
  localparam logic [NUM_MASTERS-1:0] C_DEFAULT_GRANT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MST;

  arb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_ptr;
  logic             r_lock_tail;

  htrans_t          w_trans;
  logic [CNT_W-1:0] w_beats;
  logic [3:0]       w_gidx;
  logic             w_g_lock;
  logic             w_g_req;
  logic             w_lock_req;
  logic [NUM_MASTERS-1:0] w_win_oh;
  logic [3:0]       w_win_idx;
  logic             w_win_valid;
  logic             w_burst_done;

  assign w_trans = htrans_t'(HTRANS);
  assign w_beats = CNT_W'(burst_beats(hburst_t'(HBURST)));

  // Index, lock and request of the currently granted master.
  always_comb begin
    w_gidx   = C_DEFAULT_IDX;
    w_g_lock = 1'b0;
    w_g_req  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (HGRANT[i]) begin
        w_gidx   = 4'(i);
        w_g_lock = HLOCK[i];
        w_g_req  = HBUSREQ[i];
      end
    end
  end

  assign w_lock_req = w_g_lock & w_g_req;

  // The last beat is accepted when one SEQ remains; an ERROR aborts early.
  assign w_burst_done = HRESP || ((w_trans == SEQ) && (r_cnt == CNT_W'(1)));

  ahb_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .DEFAULT_MST (DEFAULT_MST)
  ) u_rr (
    .req          (HBUSREQ),
    .ptr          (r_ptr),
    .grant_onehot (w_win_oh),
    .grant_idx    (w_win_idx),
    .valid        (w_win_valid)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ARB;
      r_cnt       <= '0;
      r_ptr       <= C_DEFAULT_IDX;
      r_lock_tail <= 1'b0;
      HGRANT      <= C_DEFAULT_GRANT;
      HMASTER     <= C_DEFAULT_IDX;
      HMASTLOCK   <= 1'b0;
    end else if (HREADY) begin
      // Address phase moves to whoever held the grant during this cycle.
      HMASTER   <= w_gidx;
      HMASTLOCK <= w_g_lock;
      unique case (r_state)
        ARB: begin
          // Lock is checked first so a locked burst stays locked.
          if (w_lock_req) begin
            r_state <= LOCKED;
          end else if ((w_trans == NONSEQ) && (w_beats > CNT_W'(1))) begin
            r_state <= BURST;
            r_cnt   <= w_beats - CNT_W'(1);
          end else begin
            HGRANT <= w_win_oh;
            r_ptr  <= w_win_valid ? w_win_idx : C_DEFAULT_IDX;
          end
        end
        BURST: begin
          if (w_burst_done) begin
            r_cnt <= '0;
            if (w_lock_req) begin
              r_state <= LOCKED;
            end else begin
              r_state <= ARB;
              HGRANT  <= w_win_oh;
              r_ptr   <= w_win_valid ? w_win_idx : C_DEFAULT_IDX;
            end
          end else if (w_trans == SEQ) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        LOCKED: begin
          // After HLOCK drops, one more ready cycle lets the final locked
          // address phase complete before the bus is re-arbitrated.
          if (r_lock_tail) begin
            r_lock_tail <= 1'b0;
            r_state     <= ARB;
            HGRANT      <= w_win_oh;
            r_ptr       <= w_win_valid ? w_win_idx : C_DEFAULT_IDX;
          end else if (!w_g_lock) begin
            r_lock_tail <= 1'b1;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

endmodule
`default_nettype wire
